// File: rtl/miriscv_decode_stage.sv
// Registered instruction-decode stage: decodes RV32I (optionally RV32M) words and
// buffers the decoded fields in a small circular queue between fetch and execute.
module miriscv_decode_stage #(
    parameter  int DEPTH        = 2,
    parameter  bit EN_MUL       = 1'b0,
    parameter  int ILL_CNT_W    = 16,
    localparam int ALU_OP_WIDTH = 5
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    fetch_valid_i,
    output logic                    fetch_ready_o,
    input  logic [31:0]             fetch_instr_i,
    input  logic [31:0]             fetch_pc_i,
    input  logic                    flush_i,
    output logic                    dec_valid_o,
    input  logic                    dec_ready_i,
    output logic [31:0]             dec_instr_o,
    output logic [31:0]             dec_pc_o,
    output logic [1:0]              a_sel_o,
    output logic [2:0]              b_sel_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic                    mul_o,
    output logic [2:0]              mul_funct_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [2:0]              mem_size_o,
    output logic                    gpr_we_o,
    output logic                    wb_src_o,
    output logic                    illegal_o,
    output logic                    branch_o,
    output logic                    jal_o,
    output logic                    jalr_o,
    output logic [ILL_CNT_W-1:0]    illegal_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] TYPE_A_RD1  = 2'd0;
    localparam logic [1:0] TYPE_A_PC   = 2'd1;
    localparam logic [1:0] TYPE_A_ZERO = 2'd2;

    localparam logic [2:0] TYPE_B_RD2   = 3'd0;
    localparam logic [2:0] TYPE_B_IMM_I = 3'd1;
    localparam logic [2:0] TYPE_B_IMM_U = 3'd2;
    localparam logic [2:0] TYPE_B_IMM_S = 3'd3;
    localparam logic [2:0] TYPE_B_INCR  = 3'd4;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 5'b00000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 5'b01000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 5'b00100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 5'b00110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 5'b00111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 5'b01101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 5'b00101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 5'b00001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS  = 5'b11100;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 5'b11110;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GES  = 5'b11101;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 5'b11111;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 5'b11000;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 5'b11001;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTS = 5'b00010;
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 5'b00011;

    localparam logic [4:0] OPCODE_LOAD          = 5'b00000;
    localparam logic [4:0] OPCODE_MISC_MEM      = 5'b00011;
    localparam logic [4:0] OPCODE_OPERATION_IMM = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC         = 5'b00101;
    localparam logic [4:0] OPCODE_STORE         = 5'b01000;
    localparam logic [4:0] OPCODE_OPERATION_REG = 5'b01100;
    localparam logic [4:0] OPCODE_LUI           = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH        = 5'b11000;
    localparam logic [4:0] OPCODE_JALR          = 5'b11001;
    localparam logic [4:0] OPCODE_JAL           = 5'b11011;
    localparam logic [4:0] OPCODE_SYSTEM        = 5'b11100;

    localparam logic [2:0] DATA_SIZE_WORD        = 3'd2;
    localparam logic       WRITEBACK_FROM_RESULT = 1'b0;
    localparam logic       WRITEBACK_FROM_DATA   = 1'b1;

    typedef struct packed {
        logic [31:0]             instr;
        logic [31:0]             pc;
        logic [1:0]              aSel;
        logic [2:0]              bSel;
        logic [ALU_OP_WIDTH-1:0] aluOp;
        logic                    mul;
        logic [2:0]              mulFunct;
        logic                    memReq;
        logic                    memWe;
        logic [2:0]              memSize;
        logic                    gprWe;
        logic                    wbSrc;
        logic                    illegal;
        logic                    branch;
        logic                    jal;
        logic                    jalr;
    } entryT;

    entryT               dec;
    entryT               legalDefault;
    entryT               head;
    entryT               mem [DEPTH];
    logic [PTR_W-1:0]    rdPtr;
    logic [PTR_W-1:0]    wrPtr;
    logic [CNT_W-1:0]    count;
    logic [ILL_CNT_W-1:0] illCnt;
    logic                ill;
    logic                full;
    logic                showHead;
    logic                push;
    logic                pop;

    logic [4:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;

    assign opcode = fetch_instr_i[6:2];
    assign func3  = fetch_instr_i[14:12];
    assign func7  = fetch_instr_i[31:25];

    always_comb begin
        legalDefault         = '0;
        legalDefault.instr   = fetch_instr_i;
        legalDefault.pc      = fetch_pc_i;
        legalDefault.aSel    = TYPE_A_RD1;
        legalDefault.bSel    = TYPE_B_RD2;
        legalDefault.aluOp   = ALU_ADD;
        legalDefault.memSize = DATA_SIZE_WORD;
        legalDefault.wbSrc   = WRITEBACK_FROM_RESULT;
    end

    // Decode fields per opcode; anything flagged illegal collapses back to the safe defaults.
    always_comb begin
        dec = legalDefault;
        ill = 1'b0;
        if (fetch_instr_i[1:0] != 2'b11) begin
            ill = 1'b1;
        end else begin
            case (opcode)
                OPCODE_LOAD: begin
                    dec.bSel    = TYPE_B_IMM_I;
                    dec.memReq  = 1'b1;
                    dec.memSize = func3;
                    dec.gprWe   = 1'b1;
                    dec.wbSrc   = WRITEBACK_FROM_DATA;
                    ill = (func3 == 3'b011) || (func3[2:1] == 2'b11);
                end
                OPCODE_STORE: begin
                    dec.bSel    = TYPE_B_IMM_S;
                    dec.memReq  = 1'b1;
                    dec.memWe   = 1'b1;
                    dec.memSize = func3;
                    ill = (func3 >= 3'd3);
                end
                OPCODE_OPERATION_IMM: begin
                    dec.bSel  = TYPE_B_IMM_I;
                    dec.gprWe = 1'b1;
                    case (func3)
                        3'b000: dec.aluOp = ALU_ADD;
                        3'b010: dec.aluOp = ALU_SLTS;
                        3'b011: dec.aluOp = ALU_SLTU;
                        3'b100: dec.aluOp = ALU_XOR;
                        3'b110: dec.aluOp = ALU_OR;
                        3'b111: dec.aluOp = ALU_AND;
                        3'b001: begin
                            dec.aluOp = ALU_SLL;
                            ill = (func7 != 7'h00);
                        end
                        default: begin
                            if (func7 == 7'h00)      dec.aluOp = ALU_SRL;
                            else if (func7 == 7'h20) dec.aluOp = ALU_SRA;
                            else                     ill = 1'b1;
                        end
                    endcase
                end
                OPCODE_OPERATION_REG: begin
                    dec.gprWe = 1'b1;
                    if (EN_MUL && func7 == 7'h01) begin
                        dec.mul      = 1'b1;
                        dec.mulFunct = func3;
                    end else begin
                        case ({func7, func3})
                            {7'h00, 3'b000}: dec.aluOp = ALU_ADD;
                            {7'h20, 3'b000}: dec.aluOp = ALU_SUB;
                            {7'h00, 3'b001}: dec.aluOp = ALU_SLL;
                            {7'h00, 3'b010}: dec.aluOp = ALU_SLTS;
                            {7'h00, 3'b011}: dec.aluOp = ALU_SLTU;
                            {7'h00, 3'b100}: dec.aluOp = ALU_XOR;
                            {7'h00, 3'b101}: dec.aluOp = ALU_SRL;
                            {7'h20, 3'b101}: dec.aluOp = ALU_SRA;
                            {7'h00, 3'b110}: dec.aluOp = ALU_OR;
                            {7'h00, 3'b111}: dec.aluOp = ALU_AND;
                            default:         ill = 1'b1;
                        endcase
                    end
                end
                OPCODE_BRANCH: begin
                    dec.branch = 1'b1;
                    case (func3)
                        3'b000:  dec.aluOp = ALU_EQ;
                        3'b001:  dec.aluOp = ALU_NE;
                        3'b100:  dec.aluOp = ALU_LTS;
                        3'b101:  dec.aluOp = ALU_GES;
                        3'b110:  dec.aluOp = ALU_LTU;
                        3'b111:  dec.aluOp = ALU_GEU;
                        default: ill = 1'b1;
                    endcase
                end
                OPCODE_JAL: begin
                    dec.aSel  = TYPE_A_PC;
                    dec.bSel  = TYPE_B_INCR;
                    dec.gprWe = 1'b1;
                    dec.jal   = 1'b1;
                end
                OPCODE_JALR: begin
                    dec.aSel  = TYPE_A_PC;
                    dec.bSel  = TYPE_B_INCR;
                    dec.gprWe = 1'b1;
                    dec.jalr  = 1'b1;
                    ill = (func3 != 3'b000);
                end
                OPCODE_LUI: begin
                    dec.aSel  = TYPE_A_ZERO;
                    dec.bSel  = TYPE_B_IMM_U;
                    dec.gprWe = 1'b1;
                end
                OPCODE_AUIPC: begin
                    dec.aSel  = TYPE_A_PC;
                    dec.bSel  = TYPE_B_IMM_U;
                    dec.gprWe = 1'b1;
                end
                OPCODE_MISC_MEM, OPCODE_SYSTEM: ;
                default: ill = 1'b1;
            endcase
        end
        if (ill) begin
            dec         = legalDefault;
            dec.illegal = 1'b1;
        end
    end

    assign full          = (count == CNT_W'(DEPTH));
    assign fetch_ready_o = !full && !rst_i;
    assign showHead      = (count != '0) && !rst_i;
    assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
    assign pop           = dec_valid_o && dec_ready_i && !flush_i;

    // Queue storage needs no reset: the head is masked to zero whenever the queue is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem[wrPtr] <= dec;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_W'(1);
            if (pop)  rdPtr <= rdPtr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            illCnt <= '0;
        end else if (push && dec.illegal && illCnt != '1) begin
            illCnt <= illCnt + ILL_CNT_W'(1);
        end
    end

    assign head          = showHead ? mem[rdPtr] : '0;
    assign dec_valid_o   = showHead;
    assign dec_instr_o   = head.instr;
    assign dec_pc_o      = head.pc;
    assign a_sel_o       = head.aSel;
    assign b_sel_o       = head.bSel;
    assign alu_op_o      = head.aluOp;
    assign mul_o         = head.mul;
    assign mul_funct_o   = head.mulFunct;
    assign mem_req_o     = head.memReq;
    assign mem_we_o      = head.memWe;
    assign mem_size_o    = head.memSize;
    assign gpr_we_o      = head.gprWe;
    assign wb_src_o      = head.wbSrc;
    assign illegal_o     = head.illegal;
    assign branch_o      = head.branch;
    assign jal_o         = head.jal;
    assign jalr_o        = head.jalr;
    assign illegal_cnt_o = rst_i ? '0 : illCnt;

endmodule

// File: tb/tb_miriscv_decode_stage.sv
// Scoreboard bench for miriscv_decode_stage: one RV32M-enabled and one RV32I-only
// instance share the same stimulus; expected entries come from a constant vector table.
module tb_miriscv_decode_stage;

    localparam int DEPTH     = 2;
    localparam int ILL_CNT_W = 2;
    localparam int CNT_MAX   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        fetchValid;
    logic [31:0] fetchInstr;
    logic [31:0] fetchPc;
    logic        flush;
    logic        decReady;

    logic        mReady, mValid, mMul, mMemReq, mMemWe, mGprWe, mWbSrc;
    logic        mIllegal, mBranch, mJal, mJalr;
    logic [31:0] mInstr, mPc;
    logic [1:0]  mASel;
    logic [2:0]  mBSel, mMulFunct, mMemSize;
    logic [4:0]  mAluOp;
    logic [ILL_CNT_W-1:0] mCnt;

    logic        iReady, iValid, iMul, iMemReq, iMemWe, iGprWe, iWbSrc;
    logic        iIllegal, iBranch, iJal, iJalr;
    logic [31:0] iInstr, iPc;
    logic [1:0]  iASel;
    logic [2:0]  iBSel, iMulFunct, iMemSize;
    logic [4:0]  iAluOp;
    logic [ILL_CNT_W-1:0] iCnt;

    miriscv_decode_stage #(.DEPTH(DEPTH), .EN_MUL(1'b1), .ILL_CNT_W(ILL_CNT_W)) dutMul (
        .clk_i(clk), .rst_i(rst),
        .fetch_valid_i(fetchValid), .fetch_ready_o(mReady),
        .fetch_instr_i(fetchInstr), .fetch_pc_i(fetchPc), .flush_i(flush),
        .dec_valid_o(mValid), .dec_ready_i(decReady),
        .dec_instr_o(mInstr), .dec_pc_o(mPc),
        .a_sel_o(mASel), .b_sel_o(mBSel), .alu_op_o(mAluOp),
        .mul_o(mMul), .mul_funct_o(mMulFunct),
        .mem_req_o(mMemReq), .mem_we_o(mMemWe), .mem_size_o(mMemSize),
        .gpr_we_o(mGprWe), .wb_src_o(mWbSrc),
        .illegal_o(mIllegal), .branch_o(mBranch), .jal_o(mJal), .jalr_o(mJalr),
        .illegal_cnt_o(mCnt)
    );

    miriscv_decode_stage #(.DEPTH(DEPTH), .EN_MUL(1'b0), .ILL_CNT_W(ILL_CNT_W)) dutBase (
        .clk_i(clk), .rst_i(rst),
        .fetch_valid_i(fetchValid), .fetch_ready_o(iReady),
        .fetch_instr_i(fetchInstr), .fetch_pc_i(fetchPc), .flush_i(flush),
        .dec_valid_o(iValid), .dec_ready_i(decReady),
        .dec_instr_o(iInstr), .dec_pc_o(iPc),
        .a_sel_o(iASel), .b_sel_o(iBSel), .alu_op_o(iAluOp),
        .mul_o(iMul), .mul_funct_o(iMulFunct),
        .mem_req_o(iMemReq), .mem_we_o(iMemWe), .mem_size_o(iMemSize),
        .gpr_we_o(iGprWe), .wb_src_o(iWbSrc),
        .illegal_o(iIllegal), .branch_o(iBranch), .jal_o(iJal), .jalr_o(iJalr),
        .illegal_cnt_o(iCnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  aSel;
        logic [2:0]  bSel;
        logic [4:0]  aluOp;
        logic        memReq;
        logic        memWe;
        logic [2:0]  memSize;
        logic        gprWe;
        logic        wbSrc;
        logic        illegal;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic        mul;
        logic [2:0]  mulFunct;
        logic        isMul;
    } vecT;

    typedef struct {
        vecT         v;
        logic [31:0] pc;
    } entryT;

    entryT scoreQ[$];
    int    testsRun    = 0;
    int    testsFailed = 0;
    int    expCnt      = 0;
    int    expCntBase  = 0;
    int    pcSerial    = 0;

    // Fields every legal non-memory decode carries, before per-instruction overrides.
    function automatic vecT baseVec(logic [31:0] instr);
        vecT v;
        v.instr = instr; v.aSel = 2'd0; v.bSel = 3'd0; v.aluOp = 5'd0;
        v.memReq = 1'b0; v.memWe = 1'b0; v.memSize = 3'd2; v.gprWe = 1'b0;
        v.wbSrc = 1'b0; v.illegal = 1'b0; v.branch = 1'b0; v.jal = 1'b0;
        v.jalr = 1'b0; v.mul = 1'b0; v.mulFunct = 3'd0; v.isMul = 1'b0;
        return v;
    endfunction

    function automatic vecT illegalVec(logic [31:0] instr);
        vecT v;
        v = baseVec(instr);
        v.illegal = 1'b1;
        return v;
    endfunction

    function automatic vecT zeroVec();
        vecT v;
        v = baseVec(32'h0);
        v.memSize = 3'd0;
        return v;
    endfunction

    function automatic vecT vecAt(int i);
        vecT v;
        case (i)
            0:  begin v = baseVec(32'h00500093); v.bSel = 3'd1; v.gprWe = 1'b1; end
            1:  begin v = baseVec(32'h002081B3); v.gprWe = 1'b1; end
            2:  begin v = baseVec(32'h402081B3); v.aluOp = 5'b01000; v.gprWe = 1'b1; end
            3:  begin
                    v = baseVec(32'h00812283); v.bSel = 3'd1; v.memReq = 1'b1;
                    v.gprWe = 1'b1; v.wbSrc = 1'b1;
                end
            4:  begin v = baseVec(32'h00512623); v.bSel = 3'd3; v.memReq = 1'b1; v.memWe = 1'b1; end
            5:  begin v = baseVec(32'h00208063); v.aluOp = 5'b11000; v.branch = 1'b1; end
            6:  begin v = baseVec(32'h000000EF); v.aSel = 2'd1; v.bSel = 3'd4; v.gprWe = 1'b1; v.jal = 1'b1; end
            7:  begin v = baseVec(32'h000010B7); v.aSel = 2'd2; v.bSel = 3'd2; v.gprWe = 1'b1; end
            8:  begin v = baseVec(32'h022081B3); v.gprWe = 1'b1; v.mul = 1'b1; v.isMul = 1'b1; end
            9:  v = illegalVec(32'h00000000);
            10: v = illegalVec(32'h0000707F);
            11: v = illegalVec(32'h00003003);
            12: v = illegalVec(32'h00001067);
            13: v = illegalVec(32'h00002063);
            14: v = illegalVec(32'h40001033);
            default: begin
                v = baseVec(32'h0220D1B3); v.gprWe = 1'b1; v.mul = 1'b1;
                v.mulFunct = 3'd5; v.isMul = 1'b1;
            end
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic checkFields(input string p, input vecT e, input logic [31:0] ePc, input bit eValid,
                               input logic valid, input logic [31:0] instr, input logic [31:0] pc,
                               input logic [1:0] aSel, input logic [2:0] bSel, input logic [4:0] aluOp,
                               input logic memReq, input logic memWe, input logic [2:0] memSize,
                               input logic gprWe, input logic wbSrc, input logic illegal,
                               input logic branch, input logic jal, input logic jalr,
                               input logic mul, input logic [2:0] mulFunct);
        checkOutput({p, "valid"},    32'(valid),    32'(eValid));
        checkOutput({p, "instr"},    instr,         e.instr);
        checkOutput({p, "pc"},       pc,            ePc);
        checkOutput({p, "aSel"},     32'(aSel),     32'(e.aSel));
        checkOutput({p, "bSel"},     32'(bSel),     32'(e.bSel));
        checkOutput({p, "aluOp"},    32'(aluOp),    32'(e.aluOp));
        checkOutput({p, "memReq"},   32'(memReq),   32'(e.memReq));
        checkOutput({p, "memWe"},    32'(memWe),    32'(e.memWe));
        checkOutput({p, "memSize"},  32'(memSize),  32'(e.memSize));
        checkOutput({p, "gprWe"},    32'(gprWe),    32'(e.gprWe));
        checkOutput({p, "wbSrc"},    32'(wbSrc),    32'(e.wbSrc));
        checkOutput({p, "illegal"},  32'(illegal),  32'(e.illegal));
        checkOutput({p, "branch"},   32'(branch),   32'(e.branch));
        checkOutput({p, "jal"},      32'(jal),      32'(e.jal));
        checkOutput({p, "jalr"},     32'(jalr),     32'(e.jalr));
        checkOutput({p, "mul"},      32'(mul),      32'(e.mul));
        checkOutput({p, "mulFunct"}, 32'(mulFunct), 32'(e.mulFunct));
    endtask

    // Compare both instances against the scoreboard head (or all-zero when empty).
    task automatic checkHead();
        vecT         e;
        vecT         eBase;
        logic [31:0] ePc;
        bit          have;
        have = scoreQ.size() > 0;
        if (have) begin
            e   = scoreQ[0].v;
            ePc = scoreQ[0].pc;
            eBase = e.isMul ? illegalVec(e.instr) : e;
        end else begin
            e = zeroVec(); eBase = zeroVec(); ePc = 32'h0;
        end
        checkFields("m.", e, ePc, have, mValid, mInstr, mPc, mASel, mBSel, mAluOp, mMemReq, mMemWe,
                    mMemSize, mGprWe, mWbSrc, mIllegal, mBranch, mJal, mJalr, mMul, mMulFunct);
        checkFields("i.", eBase, ePc, have, iValid, iInstr, iPc, iASel, iBSel, iAluOp, iMemReq, iMemWe,
                    iMemSize, iGprWe, iWbSrc, iIllegal, iBranch, iJal, iJalr, iMul, iMulFunct);
        checkOutput("m.fetchReady", 32'(mReady), 32'(scoreQ.size() < DEPTH));
        checkOutput("i.fetchReady", 32'(iReady), 32'(scoreQ.size() < DEPTH));
        checkOutput("m.illCnt", 32'(mCnt), 32'(expCnt));
        checkOutput("i.illCnt", 32'(iCnt), 32'(expCntBase));
    endtask

    // One clock cycle: drive inputs, check outputs at the falling edge, then advance the model.
    task automatic applyStimulus(input bit valid, input int idx, input bit fl, input bit ready,
                                 output bit accepted);
        vecT v;
        v = vecAt(idx);
        fetchValid = valid;
        fetchInstr = v.instr;
        fetchPc    = 32'h1000 + 32'(pcSerial * 4);
        flush      = fl;
        decReady   = ready;
        @(negedge clk);
        checkHead();
        accepted = valid && !fl && (scoreQ.size() < DEPTH);
        if (fl) begin
            scoreQ.delete();
        end else begin
            if (ready && scoreQ.size() > 0) void'(scoreQ.pop_front());
            if (accepted) begin
                scoreQ.push_back('{v: v, pc: fetchPc});
                pcSerial++;
                if (v.illegal && expCnt < CNT_MAX) expCnt++;
                if ((v.illegal || v.isMul) && expCntBase < CNT_MAX) expCntBase++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runStream(input int idxs[$], input int readyDelay, input int cycles);
        int k;
        bit acc;
        k = 0;
        for (int c = 0; c < cycles; c++) begin
            if (k < idxs.size()) applyStimulus(1'b1, idxs[k], 1'b0, c >= readyDelay, acc);
            else                 applyStimulus(1'b0, 0, 1'b0, c >= readyDelay, acc);
            if (acc) k++;
        end
    endtask

    task automatic doReset();
        rst        = 1'b1;
        fetchValid = 1'b1;
        fetchInstr = 32'h00500093;
        flush      = 1'b0;
        decReady   = 1'b0;
        @(negedge clk);
        checkFields("rst.m.", zeroVec(), 32'h0, 1'b0, mValid, mInstr, mPc, mASel, mBSel, mAluOp, mMemReq,
                    mMemWe, mMemSize, mGprWe, mWbSrc, mIllegal, mBranch, mJal, mJalr, mMul, mMulFunct);
        checkOutput("rst.m.fetchReady", 32'(mReady), 32'h0);
        checkOutput("rst.i.fetchReady", 32'(iReady), 32'h0);
        checkOutput("rst.m.illCnt", 32'(mCnt), 32'h0);
        checkOutput("rst.i.illCnt", 32'(iCnt), 32'h0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        fetchValid = 1'b0;
        scoreQ.delete();
        expCnt     = 0;
        expCntBase = 0;
    endtask

    initial begin
        int q[$];
        bit acc;
        rst = 1'b1; fetchValid = 1'b0; fetchInstr = 32'h0; fetchPc = 32'h0;
        flush = 1'b0; decReady = 1'b0;
        #1;
        doReset();

        $display("[TB] basic decode");
        q = '{0};
        runStream(q, 0, 3);

        $display("[TB] back-pressure and pointer wrap");
        q = '{1, 2, 3};
        runStream(q, 4, 9);

        $display("[TB] back-to-back legal stream");
        q = '{4, 5, 6, 7, 0};
        runStream(q, 0, 7);

        $display("[TB] illegal words and counter saturation");
        doReset();
        q = '{9, 10, 11, 12, 13, 14};
        runStream(q, 0, 8);

        $display("[TB] RV32M decode");
        doReset();
        q = '{8, 15};
        runStream(q, 0, 4);

        $display("[TB] flush");
        doReset();
        q = '{1, 2};
        runStream(q, 100, 2);
        applyStimulus(1'b1, 9, 1'b1, 1'b1, acc);
        q = '{1};
        runStream(q, 100, 1);
        applyStimulus(1'b1, 10, 1'b1, 1'b1, acc);
        q = '{};
        runStream(q, 0, 2);

        $display("[TB] reset mid-stream");
        q = '{9, 10};
        runStream(q, 0, 3);
        q = '{1};
        runStream(q, 100, 1);
        doReset();
        q = '{0};
        runStream(q, 0, 3);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
